// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: sync, filter, deframe, prefix strip (optional KBD_ARROW_DECODE_EN)
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_extended,
  output logic       scan_valid,
  output logic       err_parity,
  output logic       err_frame,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_f, data_f, clk_f_d;
  logic [FW-1:0]   clk_fcnt, data_fcnt;
  logic            fall;
  logic [7:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic            parity_bit;
  logic [TW-1:0]   to_cnt;
  logic            to_hit;
  logic            brk_flag, ext_flag;
  logic            shift_en, par_cap, good_byte, perr, ferr;
  logic            prefix_byte;

  // Two-stage synchronizers; pins idle high so they reset to 1
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], kbd_clk};
      data_sync <= {data_sync[0], kbd_data};
    end
  end

  // Stability filters: a line level changes only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_f     <= 1'b1;
      data_f    <= 1'b1;
      clk_fcnt  <= '0;
      data_fcnt <= '0;
    end else begin
      if (clk_sync[1] == clk_f) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
      if (data_sync[1] == data_f) begin
        data_fcnt <= '0;
      end else if (data_fcnt == FW'(FILTER_LEN - 1)) begin
        data_f    <= data_sync[1];
        data_fcnt <= '0;
      end else begin
        data_fcnt <= data_fcnt + 1'b1;
      end
    end
  end

  // Delayed filtered clock for falling-edge detection
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) clk_f_d <= 1'b1;
    else        clk_f_d <= clk_f;
  end

  assign fall   = clk_f_d & ~clk_f;
  assign to_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  // Frame state register
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-edge actions; a clock edge takes priority over the timeout
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    good_byte = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!data_f) state_nxt = DATA;
          else         ferr      = 1'b1;
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!data_f)                        ferr      = 1'b1;
          else if (!(^shift_reg ^ parity_bit)) perr      = 1'b1;
          else                                 good_byte = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (to_hit) begin
      state_nxt = IDLE;
      ferr      = 1'b1;
    end
  end

  // Deframing datapath: shift register, bit counter, parity capture
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (state == IDLE) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg  <= {data_f, shift_reg[7:1]};
      if (par_cap)  parity_bit <= data_f;
    end
  end

  // Mid-frame idle counter, cleared by every edge and whenever idle
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n)                          to_cnt <= '0;
    else if (fall || state == IDLE || to_hit) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

  assign prefix_byte = (shift_reg == CODE_EXT) || (shift_reg == CODE_BRK);

  // Prefix tracking, event reporting and error pulses
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      brk_flag    <= 1'b0;
      ext_flag    <= 1'b0;
      scan_code   <= '0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      scan_valid  <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      scan_valid <= good_byte && !prefix_byte;
      err_parity <= perr;
      err_frame  <= ferr;
      if (perr || ferr) begin
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
      end else if (good_byte) begin
        if (shift_reg == CODE_EXT) begin
          ext_flag <= 1'b1;
        end else if (shift_reg == CODE_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          scan_code   <= shift_reg;
          is_break    <= brk_flag;
          is_extended <= ext_flag;
          brk_flag    <= 1'b0;
          ext_flag    <= 1'b0;
        end
      end
    end
  end

`ifdef KBD_ARROW_DECODE_EN
  // Arrow hold levels follow extended make/break events
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
    end else if (good_byte && !prefix_byte && ext_flag && !perr && !ferr) begin
      case (shift_reg)
        8'h75:   up    <= ~brk_flag;
        8'h72:   down  <= ~brk_flag;
        8'h6B:   left  <= ~brk_flag;
        8'h74:   right <= ~brk_flag;
        default: ;
      endcase
    end
  end
`else
  assign up    = 1'b0;
  assign down  = 1'b0;
  assign left  = 1'b0;
  assign right = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed self-checking bench for ps2_kbd_rx
module tb_ps2_kbd_rx;

  localparam int TO_CYC = 5000;
  localparam int HFAST  = 40;
  localparam int HSLOW  = 1042;

  logic       clk_25mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       kbd_clk   = 1'b1;
  logic       kbd_data  = 1'b1;
  logic [7:0] scan_code;
  logic       is_break, is_extended, scan_valid, err_parity, err_frame;
  logic       up, down, left, right;

  int checks   = 0;
  int failures = 0;

  int         valid_cnt = 0;
  int         perr_cnt  = 0;
  int         ferr_cnt  = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_brk  = 1'b0;
  logic       last_ext  = 1'b0;

  ps2_kbd_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .kbd_clk    (kbd_clk),
    .kbd_data   (kbd_data),
    .scan_code  (scan_code),
    .is_break   (is_break),
    .is_extended(is_extended),
    .scan_valid (scan_valid),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(negedge clk_25mhz) begin
    if (scan_valid) begin
      valid_cnt = valid_cnt + 1;
      last_code = scan_code;
      last_brk  = is_break;
      last_ext  = is_extended;
    end
    if (err_parity) perr_cnt = perr_cnt + 1;
    if (err_frame)  ferr_cnt = ferr_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      kbd_data = bits[i];
      idle(half);
      kbd_clk = 1'b0;
      idle(half);
      kbd_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int half);
    send_bits({stp, par, b, 1'b0}, 11, half);
    kbd_data = 1'b1;
    idle(30);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, HFAST);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(5);
    checks++; if (scan_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", scan_code); end
    checks++; if ({is_break, is_extended, scan_valid, err_parity, err_frame} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {is_break, is_extended, scan_valid, err_parity, err_frame}); end
    checks++; if ({up, down, left, right} !== 4'b0) begin failures++; $display("FAIL reset_arrows got=%b exp=0000", {up, down, left, right}); end
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_make_slow;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, HSLOW);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL make_pulses got=%0d exp=1", valid_cnt - v0); end
    checks++; if ({last_code, last_brk, last_ext} !== {8'h1C, 2'b00}) begin failures++; $display("FAIL make_event got=%h/%b%b exp=1c/00", last_code, last_brk, last_ext); end
    checks++; if (scan_code !== 8'h1C) begin failures++; $display("FAIL make_hold got=%h exp=1c", scan_code); end
  endtask

  task automatic test_break;
    int v0, v1;
    v0 = valid_cnt;
    send_good(8'hF0);
    v1 = valid_cnt;
    checks++; if (v1 - v0 !== 0) begin failures++; $display("FAIL break_prefix_pulse got=%0d exp=0", v1 - v0); end
    send_good(8'h1C);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL break_pulses got=%0d exp=1", valid_cnt - v0); end
    checks++; if ({last_code, last_brk, last_ext} !== {8'h1C, 2'b10}) begin failures++; $display("FAIL break_event got=%h/%b%b exp=1c/10", last_code, last_brk, last_ext); end
  endtask

  task automatic test_extended;
    int v0;
    logic exp_up;
    v0 = valid_cnt;
    send_good(8'hE0);
    send_good(8'h75);
    checks++; if ({last_code, last_brk, last_ext} !== {8'h75, 2'b01}) begin failures++; $display("FAIL ext_make got=%h/%b%b exp=75/01", last_code, last_brk, last_ext); end
`ifdef KBD_ARROW_DECODE_EN
    exp_up = 1'b1;
`else
    exp_up = 1'b0;
`endif
    checks++; if (up !== exp_up) begin failures++; $display("FAIL ext_up_make got=%b exp=%b", up, exp_up); end
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL ext_pulses got=%0d exp=2", valid_cnt - v0); end
    checks++; if ({last_code, last_brk, last_ext} !== {8'h75, 2'b11}) begin failures++; $display("FAIL ext_break got=%h/%b%b exp=75/11", last_code, last_brk, last_ext); end
    checks++; if (up !== 1'b0) begin failures++; $display("FAIL ext_up_break got=%b exp=0", up); end
  endtask

  task automatic test_parity;
    int v0, p0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    send_good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b1, HFAST);
    checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL parity_pulse got=%0d exp=1", perr_cnt - p0); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL parity_no_valid got=%0d exp=0", valid_cnt - v0); end
    send_good(8'h32);
    checks++; if ({last_code, last_brk, last_ext} !== {8'h32, 2'b00}) begin failures++; $display("FAIL parity_recover got=%h/%b%b exp=32/00", last_code, last_brk, last_ext); end
  endtask

  task automatic test_frame_err;
    int v0, f0, p0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, HFAST);
    kbd_data = 1'b1;
    idle(30);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL stop_err got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (perr_cnt - p0 !== 0) begin failures++; $display("FAIL stop_over_parity got=%0d exp=0", perr_cnt - p0); end
    send_bits(11'h7FF, 1, HFAST);
    idle(30);
    checks++; if (ferr_cnt - f0 !== 2) begin failures++; $display("FAIL start_err got=%0d exp=2", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL frame_no_valid got=%0d exp=0", valid_cnt - v0); end
  endtask

  task automatic test_timeout;
    int f0, v0;
    f0 = ferr_cnt;
    send_bits(11'b0_0_0000_1010_0, 5, HFAST);
    kbd_data = 1'b1;
    idle(TO_CYC - 300);
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", ferr_cnt - f0); end
    idle(600);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL timeout_pulse got=%0d exp=1", ferr_cnt - f0); end
    v0 = valid_cnt;
    send_good(8'h1C);
    checks++; if (valid_cnt - v0 !== 1 || last_code !== 8'h1C) begin failures++; $display("FAIL timeout_recover got=%0d/%h exp=1/1c", valid_cnt - v0, last_code); end
  endtask

  task automatic test_glitch;
    int f0, v0;
    f0 = ferr_cnt;
    v0 = valid_cnt;
    kbd_data = 1'b1;
    kbd_clk = 1'b0; idle(2); kbd_clk = 1'b1;
    idle(30);
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_idle got=%0d exp=0", ferr_cnt - f0); end
    kbd_data = 1'b0;
    idle(10);
    kbd_clk = 1'b0; idle(2); kbd_clk = 1'b1;
    kbd_data = 1'b1;
    idle(30);
    send_good(8'h1C);
    checks++; if (valid_cnt - v0 !== 1 || last_code !== 8'h1C || ferr_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_frame got=%0d/%h/%0d exp=1/1c/0", valid_cnt - v0, last_code, ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int f0, p0, v0;
    send_good(8'hE0);
    send_good(8'h1C);
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_bits(11'b0_0_0000_0110_0, 4, HFAST);
    rst_n = 1'b0;
    idle(3);
    checks++; if ({scan_code, is_break, is_extended, scan_valid} !== 11'b0) begin failures++; $display("FAIL rst_mid_outputs got=%h/%b%b%b exp=00/000", scan_code, is_break, is_extended, scan_valid); end
    kbd_data = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(20);
    checks++; if (ferr_cnt - f0 !== 0 || perr_cnt - p0 !== 0) begin failures++; $display("FAIL rst_mid_no_err got=%0d/%0d exp=0/0", ferr_cnt - f0, perr_cnt - p0); end
    v0 = valid_cnt;
    send_good(8'h32);
    checks++; if (valid_cnt - v0 !== 1 || {last_code, last_brk, last_ext} !== {8'h32, 2'b00}) begin failures++; $display("FAIL rst_mid_next got=%0d/%h/%b%b exp=1/32/00", valid_cnt - v0, last_code, last_brk, last_ext); end
  endtask

  initial begin
    test_reset;
    test_make_slow;
    test_break;
    test_extended;
    test_parity;
    test_frame_err;
    test_timeout;
    test_glitch;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
